// File: rtl/axi_sram_bridge_pkg.sv
// axi_sram_bridge_pkg: bridge FSM states, AXI IDs and the latched request record
package axi_sram_bridge_pkg;
  typedef enum logic [2:0] {BR_IDLE, BR_AR, BR_R, BR_W, BR_B} br_state_e;
  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;
  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } br_req_t;
endpackage

// File: rtl/axi_sram_bridge.sv
// axi_sram_bridge: single-outstanding inst/data SRAM-to-AXI bridge; BRIDGE_EARLY_WACK_EN acks writes once AW and W are both done
module axi_sram_bridge
  import axi_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  br_state_e state_q, state_d;
  br_req_t req_q, req_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, ack;
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};
  assign araddr = req_q.addr;
  assign awaddr = req_q.addr;
  assign arid = req_q.owner ? AXI_ID_DATA : AXI_ID_INST;
  assign awid = AXI_ID_DATA;
  assign wid = AXI_ID_DATA;
  assign arsize = {1'b0, req_q.size};
  assign awsize = {1'b0, req_q.size};
  assign wdata = req_q.wdata;
  assign wstrb = req_q.wstrb;
  assign arlen = '0;
  assign awlen = '0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock = '0;
  assign awlock = '0;
  assign arcache = '0;
  assign awcache = '0;
  assign arprot = '0;
  assign awprot = '0;
  assign wlast = 1'b1;
  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;
  assign inst_sram_data_ok = ack & ~req_q.owner;
  assign data_sram_data_ok = ack & req_q.owner;
  // arbitration, request latch and one-transaction AXI sequencing
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    inst_sram_addr_ok = 1'b0;
    data_sram_addr_ok = 1'b0;
    arvalid = 1'b0;
    rready = 1'b0;
    awvalid = 1'b0;
    wvalid = 1'b0;
    bready = 1'b0;
    ack = 1'b0;
    case (state_q)
      BR_IDLE: if (!reset && (data_sram_req || inst_sram_req)) begin
        data_sram_addr_ok = data_sram_req;
        inst_sram_addr_ok = ~data_sram_req;
        req_d = data_sram_req
          ? '{1'b1, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata}
          : '{1'b0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
        state_d = req_d.wr ? BR_W : BR_AR;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
      end
      BR_AR: begin
        arvalid = 1'b1;
        state_d = arready ? BR_R : BR_AR;
      end
      BR_R: begin
        rready = 1'b1;
        ack = rvalid;
        state_d = rvalid ? BR_IDLE : BR_R;
      end
      BR_W: begin
        awvalid = ~aw_done_q;
        wvalid = ~w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d = w_done_q | wready;
        state_d = (aw_done_d && w_done_d) ? BR_B : BR_W;
`ifdef BRIDGE_EARLY_WACK_EN
        ack = aw_done_d & w_done_d;
`endif
      end
      BR_B: begin
        bready = 1'b1;
        state_d = bvalid ? BR_IDLE : BR_B;
`ifndef BRIDGE_EARLY_WACK_EN
        ack = bvalid;
`endif
      end
      default: state_d = BR_IDLE;
    endcase
  end
  // state, request latch and AW/W completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BR_IDLE;
      req_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_sram_bridge.sv
// tb_axi_sram_bridge: randomized bench with an AXI slave memory model and arbitration reference
module tb_axi_sram_bridge;
  logic clk = 1'b0;
  logic reset;
  logic inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
  logic [1:0] inst_sram_size, data_sram_size;
  logic [3:0] inst_sram_wstrb, data_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
  logic inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic [3:0] arid, awid, wid, rid, bid, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;
  int checks = 0;
  int passes = 0;
  logic [31:0] mem [logic [31:0]];
`ifdef BRIDGE_EARLY_WACK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  axi_sram_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return mem.exists(w) ? mem[w] : {w[15:0], ~w[15:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #4;
  endtask

  task automatic req_inst(input logic [31:0] a);
    inst_sram_req = 1'b1;
    inst_sram_wr = 1'b0;
    inst_sram_size = 2'd2;
    inst_sram_wstrb = 4'd0;
    inst_sram_addr = a;
    inst_sram_wdata = 32'd0;
  endtask

  task automatic req_data(input logic wr, input logic [1:0] sz, input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
    data_sram_req = 1'b1;
    data_sram_wr = wr;
    data_sram_size = sz;
    data_sram_wstrb = st;
    data_sram_addr = a;
    data_sram_wdata = d;
  endtask

  // Plays one granted transaction to completion as the AXI slave, checking against the model.
  task automatic complete(input bit is_d, input logic wr, input logic [1:0] sz, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] d, input int d1, input int d2);
    logic [31:0] exp_r, w;
    int n, db;
    settle;
    check("grant_data_addr_ok", data_sram_addr_ok, is_d);
    check("grant_inst_addr_ok", inst_sram_addr_ok, !is_d);
    check("grant_no_arvalid", {arvalid, awvalid}, 0);
    tick;
    if (is_d) data_sram_req = 1'b0;
    else inst_sram_req = 1'b0;
    if (!wr) begin
      for (int i = 0; i <= d1; i++) begin
        arready = (i == d1);
        settle;
        check("arvalid", arvalid, 1);
        check("araddr", araddr, a);
        check("busy_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
        if (i == d1) begin
          check("arid", arid, is_d ? 1 : 0);
          check("arsize", arsize, {1'b0, sz});
          check("arlen_burst", {arlen, arburst, arlock, arcache, arprot}, 32'h1 << 9);
        end
        tick;
      end
      arready = 1'b0;
      exp_r = rd_mem(a);
      for (int i = 0; i <= d2; i++) begin
        rvalid = (i == d2);
        rdata = rvalid ? exp_r : $urandom;
        settle;
        check("rready", rready, 1);
        check("owner_data_ok", is_d ? data_sram_data_ok : inst_sram_data_ok, i == d2);
        check("other_data_ok", is_d ? inst_sram_data_ok : data_sram_data_ok, 0);
        if (i == d2) check("owner_rdata", is_d ? data_sram_rdata : inst_sram_rdata, exp_r);
        tick;
      end
      rvalid = 1'b0;
    end else begin
      n = (d1 > d2) ? d1 : d2;
      for (int i = 0; i <= n; i++) begin
        awready = (i == d1);
        wready = (i == d2);
        settle;
        check("awvalid", awvalid, i <= d1);
        check("wvalid", wvalid, i <= d2);
        check("busy_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
        if (i <= d1) check("aw_fields", {awaddr[27:0], awsize, awid[0]}, {a[27:0], 1'b0, sz, 1'b1});
        if (i <= d2) check("w_fields", {wdata[23:0], wstrb, wid[2:0], wlast}, {d[23:0], st, 3'd1, 1'b1});
        check("w_data_ok", data_sram_data_ok, EARLY && i == n);
        tick;
      end
      awready = 1'b0;
      wready = 1'b0;
      db = $urandom_range(0, 3);
      for (int i = 0; i <= db; i++) begin
        bvalid = (i == db);
        settle;
        check("bready", bready, 1);
        check("b_data_ok", data_sram_data_ok, !EARLY && i == db);
        check("b_inst_data_ok", inst_sram_data_ok, 0);
        tick;
      end
      bvalid = 1'b0;
      w = rd_mem(a);
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = d[8*b +: 8];
      mem[{a[31:2], 2'b00}] = w;
    end
  endtask

  initial begin
    logic [31:0] a, ia, d;
    logic wr;
    logic [1:0] sz;
    logic [3:0] st;
    {inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata} = '0;
    {data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata} = '0;
    {arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid} = '0;
    reset = 1'b1;
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    tick;
    tick;
    settle;
    check("rst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    check("rst_araddr", araddr, 0);
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    tick;
    reset = 1'b0;
    mem[32'h1c000000] = 32'h02800c0c;
    req_inst(32'h1c000000);
    complete(0, 0, 2'd2, 4'd0, 32'h1c000000, 0, 0, 0);
    req_inst(32'h1c000004);
    req_data(0, 2'd2, 4'd0, 32'h1c000000, 0);
    complete(1, 0, 2'd2, 4'd0, 32'h1c000000, 0, 5, 1);
    complete(0, 0, 2'd2, 4'd0, 32'h1c000004, 0, 1, 0);
    req_data(1, 2'd1, 4'b0011, 32'h1c0000f0, 32'hdeadbeef);
    complete(1, 1, 2'd1, 4'b0011, 32'h1c0000f0, 32'hdeadbeef, 0, 3);
    req_data(0, 2'd2, 4'd0, 32'h1c0000f0, 0);
    complete(1, 0, 2'd2, 4'd0, 32'h1c0000f0, 0, 0, 2);
    req_inst(32'h1c000100);
    settle;
    check("rst_r_grant", inst_sram_addr_ok, 1);
    tick;
    inst_sram_req = 1'b0;
    arready = 1'b1;
    tick;
    arready = 1'b0;
    settle;
    check("rst_r_rready", rready, 1);
    tick;
    reset = 1'b1;
    tick;
    settle;
    check("rst_r_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rst_r_oks", {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}, 0);
    check("rst_r_araddr", araddr, 0);
    tick;
    reset = 1'b0;
    req_inst(32'h1c000100);
    complete(0, 0, 2'd2, 4'd0, 32'h1c000100, 0, 0, 1);
    for (int k = 0; k < 40; k++) begin
      a = 32'h1c000000 + 32'($urandom_range(0, 7)) * 4;
      ia = 32'h1c000000 + 32'($urandom_range(0, 7)) * 4;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      st = 4'($urandom_range(1, 15));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        req_inst(ia);
        req_data(wr, sz, st, a, d);
        complete(1, wr, sz, st, a, d, $urandom_range(0, 3), $urandom_range(0, 3));
        complete(0, 0, 2'd2, 4'd0, ia, 0, $urandom_range(0, 3), $urandom_range(0, 3));
      end else if ($urandom_range(0, 1) == 1) begin
        req_data(wr, sz, st, a, d);
        complete(1, wr, sz, st, a, d, $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        req_inst(ia);
        complete(0, 0, 2'd2, 4'd0, ia, 0, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
